cdb_slot_arbiter: RTL
=====================

// Module: cdb_slot_arbiter
// PURPOSE
//  Parametrised CDB reservation/arbitration unit for NUM_CH fixed-latency execution channels.
//  Grants issue requests only when the channel's future CDB write-back slot is free.
//  Round-robin resolves same-cycle contention.
//  Muxes the owning channel's result into a registered CDB (valid/data/tag).
//  Sits between the issue queues and the execution units; replaces hard-wired 4-unit slot logic.
// PARAMETERS
//  NUM_CH   4        number of execution channels (2..8)
//  MAX_LAT  8        reservation window depth; every CH_LAT entry is in 1..MAX_LAT
//  CH_LAT   16'h6311 packed 4b latency per channel, ch0 in LSBs (int=1, ls=1, mult=3, div=6)
//  DATA_W   32       CDB data width
//  TAG_W    6        CDB tag width
// PORTS
//  clk               in   1               clock
//  reset             in   1               synchronous, active-high
//  ch_req            in   NUM_CH          channel has an instruction ready to issue
//  ch_busy           in   NUM_CH          unit is non-pipelined and currently occupied; blocks grant
//  ch_grant          out  NUM_CH          combinational; issue accepted this cycle (queue "done")
//  ch_nowb           in   NUM_CH          sampled at capture; result has no write-back (e.g. store)
//  ch_data           in   NUM_CH*DATA_W   unit results, valid in the channel's capture cycle
//  ch_tag            in   NUM_CH*TAG_W    unit result tags, valid in the capture cycle
//  cdb_valid         out  1               registered CDB write-back strobe
//  cdb_data          out  DATA_W          registered CDB data
//  cdb_tag           out  TAG_W           registered CDB tag
//  ch_branch,ch_taken in  NUM_CH          present only with CDB_BRANCH_EN
//  cdb_branch,cdb_branch_taken out 1      present only with CDB_BRANCH_EN
// BEHAVIOUR
//  - Timing: grant in cycle t with latency L -> unit result on ch_data/ch_tag in cycle t+L-1 (capture).
//    The result is registered and appears on cdb_* in cycle t+L.
//  - Reservation table res_r[0..MAX_LAT-1] plus owner_r[] (clog2(NUM_CH) bits each).
//    res_r[j]=1 means a capture is owned j cycles from now.
//  - Grant condition for ch i: ch_req & ~ch_busy & ~res_r[L-1] & slot L-1 not claimed by a higher-priority grant this cycle.
//  - Priority order: rr_ptr, rr_ptr+1, ... mod NUM_CH.
//  - Next state: res[j] = res_r[j+1] | grant with L-1==j+1; owner likewise.
//    res[MAX_LAT-1] takes only new claims.
//  - Capture this cycle: owner = owner_r[0] if res_r[0], else the L=1 channel granted now.
//  - cdb_valid <= capture & ~ch_nowb[owner]; cdb_data/tag <= owner's ch_data/ch_tag.
//  - No capture: cdb_valid, cdb_data and cdb_tag all load 0.
//  - rr_ptr advances to (highest-priority granted ch)+1 only when some requester lost to a same-cycle claim.
//    Otherwise it holds (generalises int/ls priority toggle).
//  - At most one grant per slot; multiple grants per cycle are allowed for distinct latencies.
//  - Reset: res_r, owner_r, rr_ptr=0, and all cdb_* = 0. ch_grant=0 while reset is high.
//    In-flight results are discarded, never broadcast.
//  - Elaboration $error if any CH_LAT entry is 0 or >MAX_LAT, or NUM_CH is out of range.
// CONFIGURATION
//  CDB_BRANCH_EN defined:
//   - cdb_branch <= capture & ch_branch[owner]; cdb_branch_taken <= capture & ch_taken[owner].
//   - cdb_valid is forced 0 when cdb_branch is 1.
//   - Both branch outputs reset to 0.
//  CDB_BRANCH_EN undefined: branch ports are absent; no branch logic.
// STRUCTURE
//  - Shared package/header: CDB_DATA_W, CDB_TAG_W defaults and the lat_of(i) helper for CH_LAT slicing.
//  - One sub-module: cdb_rr_picker (rotating-priority first-free selector per slot).
//    The top holds the reservation shift register and the CDB output register.
// TESTING (defaults; cycle t after reset release)
//  1 ch0 req t, data 0x1234 tag 5 -> ch_grant[0]=1 at t; cdb_valid=1 data 0x1234 tag 5 at t+1.
//  2 ch0 & ch1 req every cycle -> grants ch0 t, ch1 t+1, ch0 t+2 (alternate); one cdb_valid per cycle.
//  3 ch2 grant t; ch0 req t+2 -> denied t+2, granted t+3; CDB: mult at t+3, int at t+4.
//  4 ch3 grant t; ch2 req t+3 -> denied (slot t+5 owned), granted t+4; div on CDB at t+6, mult at t+7.
//  5 ch1 grant, ch_nowb[1]=1 -> cdb_valid=0 at t+1; ch0 at t+1 still blocked from that slot.
//  6 ch3 grant t, reset high at t+2 -> no cdb_valid at t+6; all outputs 0.
//    (CDB_BRANCH_EN: ch0 ch_branch=1 ch_taken=1 -> cdb_branch=1, taken=1, valid=0.)

Source files
------------

// File: rtl/cdb_slot_arbiter_pkg.sv
// ============================================================================
// Module  : cdb_slot_arbiter_pkg
// Brief   : Shared CDB widths and channel-latency helper for the slot arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cdb_slot_arbiter_pkg;

  localparam int CDB_DATA_W = 32;
  localparam int CDB_TAG_W  = 6;
  localparam int CDB_LAT_W  = 4;

  // Latency of channel i from the packed CH_LAT vector (ch0 in the LSBs).
  function automatic int lat_of(input logic [31:0] ch_lat, input int i);
    logic [31:0] shifted;
    shifted = ch_lat >> (CDB_LAT_W * i);
    return int'(shifted[CDB_LAT_W-1:0]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cdb_rr_picker.sv
// ============================================================================
// Module  : cdb_rr_picker
// Brief   : Rotating-priority selector granting each write-back slot to the
//           first eligible channel, starting from the round-robin pointer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_rr_picker
  import cdb_slot_arbiter_pkg::*;
#(
  parameter int          NUM_CH  = 4,
  parameter int          MAX_LAT = 8,
  parameter int          PTR_W   = 2,
  parameter int          SLOT_W  = 3,
  parameter logic [31:0] CH_LAT  = 32'h0000_6311
) (
  input  logic [NUM_CH-1:0]               i_elig,
  input  logic [PTR_W-1:0]                i_rr_ptr,
  output logic [NUM_CH-1:0]               o_grant,
  output logic [MAX_LAT-1:0]              o_claim,
  output logic [MAX_LAT-1:0][PTR_W-1:0]   o_claim_own,
  output logic                            o_lost,
  output logic [PTR_W-1:0]                o_first
);

  logic              w_found;
  int                w_sum;
  logic [PTR_W-1:0]  w_idx;
  logic [SLOT_W-1:0] w_slot;

  always_comb begin
    o_grant     = '0;
    o_claim     = '0;
    o_claim_own = '0;
    o_lost      = 1'b0;
    o_first     = '0;
    w_found     = 1'b0;
    w_sum       = 0;
    w_idx       = '0;
    w_slot      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_sum = int'(i_rr_ptr) + k;
      if (w_sum >= NUM_CH) begin
        w_sum = w_sum - NUM_CH;
      end
      w_idx  = PTR_W'(w_sum);
      w_slot = SLOT_W'(lat_of(CH_LAT, w_sum) - 1);
      if (i_elig[w_idx]) begin
        // A slot already taken by an earlier-priority channel is a same-cycle loss.
        if (o_claim[w_slot]) begin
          o_lost = 1'b1;
        end else begin
          o_grant[w_idx]      = 1'b1;
          o_claim[w_slot]     = 1'b1;
          o_claim_own[w_slot] = w_idx;
          if (!w_found) begin
            w_found = 1'b1;
            o_first = w_idx;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cdb_slot_arbiter.sv
// ============================================================================
// Module  : cdb_slot_arbiter
// Brief   : CDB write-back slot reservation, round-robin issue arbitration and
//           registered result broadcast. Optional branch outputs: CDB_BRANCH_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_slot_arbiter
  import cdb_slot_arbiter_pkg::*;
#(
  parameter int                    NUM_CH  = 4,
  parameter int                    MAX_LAT = 8,
  parameter logic [4*NUM_CH-1:0]   CH_LAT  = 16'h6311,
  parameter int                    DATA_W  = CDB_DATA_W,
  parameter int                    TAG_W   = CDB_TAG_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         ch_req,
  input  logic [NUM_CH-1:0]         ch_busy,
  output logic [NUM_CH-1:0]         ch_grant,
  input  logic [NUM_CH-1:0]         ch_nowb,
  input  logic [NUM_CH*DATA_W-1:0]  ch_data,
  input  logic [NUM_CH*TAG_W-1:0]   ch_tag,
  output logic                      cdb_valid,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [TAG_W-1:0]          cdb_tag
`ifdef CDB_BRANCH_EN
  ,
  input  logic [NUM_CH-1:0]         ch_branch,
  input  logic [NUM_CH-1:0]         ch_taken,
  output logic                      cdb_branch,
  output logic                      cdb_branch_taken
`endif
);

  localparam int          c_PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int          c_SLOT_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [31:0] c_CH_LAT = 32'(CH_LAT);

  if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
    $error("cdb_slot_arbiter: NUM_CH=%0d outside 2..8", NUM_CH);
  end

  logic [MAX_LAT-1:0]                r_res;
  logic [MAX_LAT-1:0][c_PTR_W-1:0]   r_owner;
  logic [c_PTR_W-1:0]                r_rr;

  logic [NUM_CH-1:0]                 w_elig;
  logic [MAX_LAT-1:0]                w_claim;
  logic [MAX_LAT-1:0][c_PTR_W-1:0]   w_claim_own;
  logic                              w_lost;
  logic [c_PTR_W-1:0]                w_first;
  logic [c_PTR_W-1:0]                w_rr_nxt;
  logic [MAX_LAT-1:0]                w_res_nxt;
  logic [MAX_LAT-1:0][c_PTR_W-1:0]   w_owner_nxt;
  logic                              w_cap;
  logic [c_PTR_W-1:0]                w_own;
  logic [DATA_W-1:0]                 w_data_a [NUM_CH];
  logic [TAG_W-1:0]                  w_tag_a  [NUM_CH];
  logic                              w_br;
  logic                              w_cdb_valid;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam int c_LAT  = lat_of(c_CH_LAT, i);
    localparam int c_SLOT = c_LAT - 1;

    if (c_LAT < 1 || c_LAT > MAX_LAT) begin : g_bad_lat
      $error("cdb_slot_arbiter: channel %0d latency %0d outside 1..%0d", i, c_LAT, MAX_LAT);
    end

    // Reset forces the eligibility low so no grant escapes during reset.
    assign w_elig[i]   = ch_req[i] & ~ch_busy[i] & ~r_res[c_SLOT] & ~reset;
    assign w_data_a[i] = ch_data[i*DATA_W +: DATA_W];
    assign w_tag_a[i]  = ch_tag[i*TAG_W +: TAG_W];
  end

  cdb_rr_picker #(
    .NUM_CH  (NUM_CH),
    .MAX_LAT (MAX_LAT),
    .PTR_W   (c_PTR_W),
    .SLOT_W  (c_SLOT_W),
    .CH_LAT  (c_CH_LAT)
  ) u_picker (
    .i_elig      (w_elig),
    .i_rr_ptr    (r_rr),
    .o_grant     (ch_grant),
    .o_claim     (w_claim),
    .o_claim_own (w_claim_own),
    .o_lost      (w_lost),
    .o_first     (w_first)
  );

  assign w_rr_nxt = (w_first == c_PTR_W'(NUM_CH - 1)) ? '0 : w_first + c_PTR_W'(1);

  // Table shifts one slot toward "now"; a grant of latency L lands at index L-2.
  always_comb begin
    w_res_nxt   = '0;
    w_owner_nxt = '0;
    for (int j = 0; j < MAX_LAT - 1; j++) begin
      w_res_nxt[j]   = r_res[j+1] | w_claim[j+1];
      w_owner_nxt[j] = w_claim[j+1] ? w_claim_own[j+1] : r_owner[j+1];
    end
  end

  always_comb begin
    w_cap = 1'b0;
    w_own = '0;
    if (r_res[0]) begin
      w_cap = 1'b1;
      w_own = r_owner[0];
    end else if (w_claim[0]) begin
      w_cap = 1'b1;
      w_own = w_claim_own[0];
    end
  end

`ifdef CDB_BRANCH_EN
  assign w_br = w_cap & ch_branch[w_own];
`else
  assign w_br = 1'b0;
`endif

  assign w_cdb_valid = w_cap & ~ch_nowb[w_own] & ~w_br;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_res            <= '0;
      r_owner          <= '0;
      r_rr             <= '0;
      cdb_valid        <= 1'b0;
      cdb_data         <= '0;
      cdb_tag          <= '0;
`ifdef CDB_BRANCH_EN
      cdb_branch       <= 1'b0;
      cdb_branch_taken <= 1'b0;
`endif
    end else begin
      r_res     <= w_res_nxt;
      r_owner   <= w_owner_nxt;
      if (w_lost) begin
        r_rr <= w_rr_nxt;
      end
      cdb_valid <= w_cdb_valid;
      cdb_data  <= w_cap ? w_data_a[w_own] : '0;
      cdb_tag   <= w_cap ? w_tag_a[w_own] : '0;
`ifdef CDB_BRANCH_EN
      cdb_branch       <= w_br;
      cdb_branch_taken <= w_cap & ch_taken[w_own];
`endif
    end
  end

endmodule

`default_nettype wire
